// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the register-file/control side and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Optional MULDIV_FAST_MULT_EN: multiplies finish combinationally at launch; divides stay iterative.
module hilo_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input logic          clk,
    input logic          reset,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic              w_busy;
    logic              w_done;
    logic              w_launch;
    logic              w_fast_op;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_neg_rs;
    logic              w_neg_rt;
    logic [XLEN-1:0]   w_mag_rs;
    logic [XLEN-1:0]   w_mag_rt;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [XLEN-1:0]   w_acc_nx;
    logic [XLEN-1:0]   w_q_nx;
    logic              w_neg_res;
    logic [2*XLEN-1:0] w_mag_prod;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

`ifdef MULDIV_FAST_MULT_EN
    logic signed [2*XLEN-1:0] w_ext_rs;
    logic signed [2*XLEN-1:0] w_ext_rt;
    logic signed [2*XLEN-1:0] w_fast_prod;

    // Zero- or sign-extend to full width so one wide multiply covers both MULT and MULTU.
    assign w_ext_rs    = bus.op[0] ? {{XLEN{1'b0}}, bus.rs_data} : {{XLEN{bus.rs_data[XLEN-1]}}, bus.rs_data};
    assign w_ext_rt    = bus.op[0] ? {{XLEN{1'b0}}, bus.rt_data} : {{XLEN{bus.rt_data[XLEN-1]}}, bus.rt_data};
    assign w_fast_prod = w_ext_rs * w_ext_rt;
    assign w_fast_op   = ~bus.op[1];
`else
    assign w_fast_op   = 1'b0;
`endif

    assign w_launch  = bus.start && (r_state != S_RUN);
    assign w_neg_rs  = ~bus.op[0] & bus.rs_data[XLEN-1];
    assign w_neg_rt  = ~bus.op[0] & bus.rt_data[XLEN-1];
    assign w_mag_rs  = w_neg_rs ? -bus.rs_data : bus.rs_data;
    assign w_mag_rt  = w_neg_rt ? -bus.rt_data : bus.rt_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == '0) w_state_nx = S_DONE;
            end
            default: begin
                w_done = (r_state == S_DONE);
                if (bus.start) w_state_nx = w_fast_op ? S_DONE : S_RUN;
                else           w_state_nx = S_IDLE;
            end
        endcase
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_shift = {r_acc, r_q[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (r_is_div) begin
            w_acc_nx = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            w_q_nx   = {r_q[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
            w_acc_nx = w_sum[XLEN:1];
            w_q_nx   = {w_sum[0], r_q[XLEN-1:1]};
        end
    end

    assign w_neg_res  = r_neg_a ^ r_neg_b;
    assign w_mag_prod = {w_acc_nx, w_q_nx};
    assign w_prod     = w_neg_res ? -w_mag_prod : w_mag_prod;
    assign w_quo      = w_neg_res ? -w_q_nx : w_q_nx;
    assign w_rem      = r_neg_a ? -w_acc_nx : w_acc_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_q      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_launch) begin
            r_cnt    <= CW'(ITER - 1);
            r_is_div <= bus.op[1];
            r_neg_a  <= w_neg_rs;
            r_neg_b  <= w_neg_rt;
            r_a      <= bus.rs_data;
            r_acc    <= '0;
            r_q      <= bus.op[1] ? w_mag_rs : w_mag_rt;
            r_b      <= bus.op[1] ? w_mag_rt : w_mag_rs;
`ifdef MULDIV_FAST_MULT_EN
            if (!bus.op[1]) begin
                r_hi <= w_fast_prod[2*XLEN-1:XLEN];
                r_lo <= w_fast_prod[XLEN-1:0];
            end
`endif
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 1'b1;
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            if (r_cnt == '0) begin
                if (!r_is_div) begin
                    r_hi <= w_prod[2*XLEN-1:XLEN];
                    r_lo <= w_prod[XLEN-1:0];
                end else if (r_b == '0) begin
                    r_hi <= r_a;
                    r_lo <= '1;
                end else begin
                    r_hi <= w_rem;
                    r_lo <= w_quo;
                end
            end
        end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized checks of hilo_muldiv_unit against an arithmetic reference model.
module tb_hilo_muldiv_unit;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv_if #(.XLEN(32)) bus();

    hilo_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] ua;
        logic [63:0] ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b00: ref_model = 64'(sa * sb);
            2'b01: ref_model = ua * ub;
            2'b10: begin
                if (b == 32'h0) ref_model = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'h0) ref_model = {a, 32'hFFFF_FFFF};
                else ref_model = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic lw);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.lo_we   = lw;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output int dcyc);
        nbusy = 0;
        dcyc  = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) nbusy++;
            if (bus.done === 1'b1) begin
                dcyc = k;
                break;
            end
        end
    endtask

    task automatic run_check(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int nb;
        int dc;
        int exp_nb;
        int exp_dc;
        exp    = ref_model(op, a, b);
        exp_nb = 32;
        exp_dc = 33;
`ifdef MULDIV_FAST_MULT_EN
        if (!op[1]) begin
            exp_nb = 0;
            exp_dc = 1;
        end
`endif
        run_op(op, a, b, 1'b0);
        wait_done(nb, dc);
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_nb));
        check({tag, "_done_cycle"}, 32'(dc), 32'(exp_dc));
        check({tag, "_hi"}, bus.hi, exp[63:32]);
        check({tag, "_lo"}, bus.lo, exp[31:0]);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    initial begin
        int nb;
        int dc;
        logic [63:0] exp;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec = 0;
        n_err = 0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = 32'h0;
        bus.rt_data = 32'h0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wdata   = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_check(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
        check("multu_hi_const", bus.hi, 32'h0000_0001);
        check("multu_lo_const", bus.lo, 32'hFFFF_FFFE);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'h0);
        run_check(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, "mult");
        check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        run_check(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg");
        check("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
        run_check(2'b11, 32'd100, 32'd7, "divu");
        check("divu_lo_const", bus.lo, 32'd14);
        run_check(2'b11, 32'h1234_5678, 32'h0, "divu_zero");
        run_check(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_lo_const", bus.lo, 32'h8000_0000);
        @(negedge clk);

        bus.hi_we = 1'b1;
        bus.wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        check("mthi", bus.hi, 32'hAAAA_5555);
        m_hi = 32'hAAAA_5555;
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0F0F_1234;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        check("mt_both_hi", bus.hi, 32'h0F0F_1234);
        check("mt_both_lo", bus.lo, 32'h0F0F_1234);
        m_hi = 32'h0F0F_1234;
        m_lo = 32'h0F0F_1234;
        @(negedge clk);

        run_op(2'b11, 32'd1000, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("hi_we_in_run", bus.hi, m_hi);
        wait_done(nb, dc);
        check("hi_we_in_run_hi", bus.hi, 32'd1);
        check("hi_we_in_run_lo", bus.lo, 32'd333);
        m_hi = bus.hi;
        m_lo = bus.lo;
        @(negedge clk);

        bus.wdata = 32'h5555_AAAA;
        run_op(2'b11, 32'd77, 32'd5, 1'b1);
        check("start_lo_we_lo", bus.lo, m_lo);
        check("start_lo_we_busy", 32'(bus.busy), 32'h1);
        wait_done(nb, dc);
        check("start_lo_we_res_lo", bus.lo, 32'd15);
        check("start_lo_we_res_hi", bus.hi, 32'd2);
        @(negedge clk);

        run_op(2'b11, 32'd500, 32'd9, 1'b0);
        repeat (4) @(negedge clk);
        bus.op      = 2'b01;
        bus.rs_data = 32'd7;
        bus.rt_data = 32'd1;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(nb, dc);
        check("restart_ignored_lo", bus.lo, 32'd55);
        check("restart_ignored_hi", bus.hi, 32'd5);
        @(negedge clk);

        run_op(2'b11, 32'hFFFF_0000, 32'd13, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_done", 32'(bus.done), 32'h0);
        check("midrst_hi", bus.hi, 32'h0);
        check("midrst_lo", bus.lo, 32'h0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_check(2'b11, 32'd9, 32'd3, "post_rst_divu");
        check("post_rst_lo_const", bus.lo, 32'd3);
        check("post_rst_hi_const", bus.hi, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            exp = ref_model(rop, ra, rb);
            run_check(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
            if (exp != {m_hi, m_lo}) n_err++;
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
